// File: rtl/determ_mult_fxp_arb.sv
// Round-robin arbiter sharing one bitstream x FXP multiplier among NUM_REQ
// requesters. The winning requester's coefficient is passed (bit=1) or
// negated (bit=0) into a single registered output slot tagged with its ID.
module determ_mult_fxp_arb #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned NUM_REQ   = 4,
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_a,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BIT_WIDTH-1:0]         out_y,
  output logic [ID_W-1:0]              out_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [BIT_WIDTH-1:0] out_y_q, out_y_d;
  logic [ID_W-1:0]      out_id_q, out_id_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;

  logic                 can_load;
  logic                 found;
  logic [ID_W-1:0]      gnt_idx;
  logic [NUM_REQ-1:0]   grant_vec;
  logic [BIT_WIDTH-1:0] sel_b;
  logic                 sel_a;

  // Round-robin search: first pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
  always_comb begin
    can_load  = (state_q == EMPTY) || out_ready;
    found     = 1'b0;
    gnt_idx   = '0;
    grant_vec = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && (32'(ptr_q) <= i) && req_valid[i]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
    if (can_load && found) begin
      grant_vec[gnt_idx] = 1'b1;
    end
  end

  // Grant is suppressed while reset is asserted since the EMPTY state would otherwise allow loads.
  always_comb begin
    req_ready = nRST ? grant_vec : '0;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_b = '0;
    sel_a = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_b = req_b[i*BIT_WIDTH +: BIT_WIDTH];
        sel_a = req_a[i];
      end
    end
  end

  // Next-state: load on grant, drain to EMPTY when consumed without a new request, else hold.
  always_comb begin
    state_d  = state_q;
    out_y_d  = out_y_q;
    out_id_d = out_id_q;
    ptr_d    = ptr_q;
    if (can_load && found) begin
      state_d  = FULL;
      out_y_d  = sel_a ? sel_b : -sel_b;
      out_id_d = gnt_idx;
      ptr_d    = ID_W'((32'(gnt_idx) + 1) % NUM_REQ);
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= EMPTY;
      out_y_q  <= '0;
      out_id_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_y_q  <= out_y_d;
      out_id_q <= out_id_d;
      ptr_q    <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_y     = out_y_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_determ_mult_fxp_arb.sv
// Self-checking bench for determ_mult_fxp_arb: table of single-request vectors,
// hand-written round-robin / backpressure / reset sequences, and random traffic,
// all checked through an expected-result queue and a reference arbiter model.
module tb_determ_mult_fxp_arb;

  localparam int BW = 16;
  localparam int N  = 4;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_a;
  logic [N*BW-1:0] req_b;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_y;
  logic [1:0]    out_id;

  determ_mult_fxp_arb #(.BIT_WIDTH(BW), .NUM_REQ(N)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_id    (out_id)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [BW-1:0] y;
    logic [1:0]    id;
  } exp_t;

  typedef struct {
    logic [3:0]    valid;
    logic [3:0]    a;
    logic [BW-1:0] b;
    logic [1:0]    exp_id;
    logic [BW-1:0] exp_y;
  } vec_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   ptr_m    = 0;
  bit   full_m   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*BW-1:0] bcast(input logic [BW-1:0] b);
    return {N{b}};
  endfunction

  // One clock cycle of traffic: checks the combinational grant and the output
  // slot against the model, then advances the model and the clock.
  task automatic cycle(input logic [3:0] v, input logic [3:0] a, input logic [N*BW-1:0] bv,
                       input logic ordy, input bit use_exp, input logic [BW-1:0] ey,
                       input logic [1:0] eid);
    int g;
    bit can;
    logic [3:0] exp_rr;
    logic [N*BW-1:0] sh;
    logic [BW-1:0] bg;
    exp_t e;
    req_valid = v;
    req_a     = a;
    req_b     = bv;
    out_ready = ordy;
    #1;
    can = !full_m || ordy;
    g   = -1;
    if (can) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (ptr_m + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rr = (g >= 0) ? 4'(1 << g) : 4'b0000;
    check("req_ready", 32'(req_ready), 32'(exp_rr));
    check("out_valid", 32'(out_valid), 32'(full_m));
    if (full_m) begin
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL scoreboard_empty: got out_valid=1 expected a queued result");
      end else begin
        check("out_y", 32'(out_y), 32'(sb[0].y));
        check("out_id", 32'(out_id), 32'(sb[0].id));
        if (ordy) void'(sb.pop_front());
      end
    end
    if (g >= 0) begin
      sh = bv >> (g * BW);
      bg = sh[BW-1:0];
      if (use_exp) begin
        e.y  = ey;
        e.id = eid;
      end else begin
        e.y  = a[g] ? bg : (~bg + 16'd1);
        e.id = 2'(g);
      end
      sb.push_back(e);
      ptr_m  = (g + 1) % N;
      full_m = 1'b1;
    end else if (full_m && ordy) begin
      full_m = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(4'b0000, 4'b0000, '0, ordy, 1'b0, '0, 2'd0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b1;
    nRST      = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_y", 32'(out_y), 32'd0);
    check("reset_out_id", 32'(out_id), 32'd0);
    nRST = 1'b1;
    ptr_m  = 0;
    full_m = 1'b0;
    sb.delete();
    #1;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{valid: 4'b0001, a: 4'hF, b: 16'h1234, exp_id: 2'd0, exp_y: 16'h1234};
    vecs[1] = '{valid: 4'b0010, a: 4'h0, b: 16'h0005, exp_id: 2'd1, exp_y: 16'hFFFB};
    vecs[2] = '{valid: 4'b0100, a: 4'h0, b: 16'h8000, exp_id: 2'd2, exp_y: 16'h8000};
    vecs[3] = '{valid: 4'b1000, a: 4'h0, b: 16'h0000, exp_id: 2'd3, exp_y: 16'h0000};
    vecs[4] = '{valid: 4'b0001, a: 4'h0, b: 16'h7FFF, exp_id: 2'd0, exp_y: 16'h8001};
    vecs[5] = '{valid: 4'b0100, a: 4'hF, b: 16'hFFFF, exp_id: 2'd2, exp_y: 16'hFFFF};
    vecs[6] = '{valid: 4'b1001, a: 4'h0, b: 16'hFFFE, exp_id: 2'd3, exp_y: 16'h0002};

    nRST = 1'b0;
    do_reset();

    // Table vectors: single requesters, back-to-back with out_ready high.
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].valid, vecs[i].a, bcast(vecs[i].b), 1'b1, 1'b1, vecs[i].exp_y, vecs[i].exp_id);
    end
    idle(1'b1);
    idle(1'b1);

    // All requesters valid: rotating grants, one result per cycle.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1111, 4'b1010, {16'h0040, 16'h0030, 16'h0020, 16'h0010}, 1'b1, 1'b0, '0, 2'd0);
    end

    // Backpressure: slot full, no grants, output held; then resume.
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 4'b0101, {16'h0400, 16'h0300, 16'h0200, 16'h0100}, 1'b0, 1'b0, '0, 2'd0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 4'b0101, {16'h0400, 16'h0300, 16'h0200, 16'h0100}, 1'b1, 1'b0, '0, 2'd0);
    end
    idle(1'b1);
    idle(1'b1);

    // Pointer only moves on grants: grant 1, then 0, idle, then all valid -> 1.
    do_reset();
    cycle(4'b0010, 4'hF, bcast(16'h0011), 1'b1, 1'b0, '0, 2'd0);
    cycle(4'b0001, 4'hF, bcast(16'h0022), 1'b1, 1'b0, '0, 2'd0);
    repeat (3) idle(1'b1);
    cycle(4'b1111, 4'hF, bcast(16'h0033), 1'b1, 1'b0, '0, 2'd0);
    idle(1'b1);

    // Async reset mid-stream while the slot is full.
    cycle(4'b1111, 4'hF, bcast(16'h5555), 1'b1, 1'b0, '0, 2'd0);
    cycle(4'b1111, 4'hF, bcast(16'h6666), 1'b0, 1'b0, '0, 2'd0);
    req_valid = 4'b1111;
    #1;
    nRST = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_y", 32'(out_y), 32'd0);
    check("async_out_id", 32'(out_id), 32'd0);
    check("async_req_ready", 32'(req_ready), 32'd0);
    @(posedge CLK);
    #1;
    nRST   = 1'b1;
    ptr_m  = 0;
    full_m = 1'b0;
    sb.delete();
    #1;
    cycle(4'b1111, 4'hF, bcast(16'h0777), 1'b1, 1'b0, '0, 2'd0);
    cycle(4'b1111, 4'hF, bcast(16'h0777), 1'b1, 1'b0, '0, 2'd0);
    idle(1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 60; i++) begin
      cycle(4'($urandom), 4'($urandom), {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)},
            1'($urandom_range(0, 3) != 0), 1'b0, '0, 2'd0);
    end
    repeat (3) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
